// File: rtl/vga_fb_ctrl_pkg.sv
// Shared types and helpers for the iob_vga frame-buffer controller.
// Optional CPU read path is enabled by defining VGA_FB_CPU_RD_EN.
package vga_fb_ctrl_pkg;

  localparam int RGB_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

  // FIFO pointer width; the occupancy counter is one bit wider.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Pixel prefetch FIFO: power-of-two depth, flush has priority over push/pop.
// Pop on empty is ignored; push on a full FIFO is accepted only alongside a pop.
module vga_pixel_fifo
  import vga_fb_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = RGB_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vga_fb_ctrl.sv
// Frame-buffer arbiter: raster-order display prefetch has priority, CPU takes idle slots.
// Define VGA_FB_CPU_RD_EN to add CPU reads (cpu_we/cpu_rdata/cpu_rvalid).
module vga_fb_ctrl
  import vga_fb_ctrl_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic              disp_active,
  output logic [RGB_W-1:0]  rgb,
  output logic              underrun,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [RGB_W-1:0]  cpu_wdata,
`ifdef VGA_FB_CPU_RD_EN
  input  logic              cpu_we,
  output logic [RGB_W-1:0]  cpu_rdata,
  output logic              cpu_rvalid,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RGB_W-1:0]  mem_wdata,
  input  logic [RGB_W-1:0]  mem_rdata
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [PW+1:0]     DEPTH_L   = (PW+2)'(FIFO_DEPTH);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [RGB_W-1:0]  rgb_q;
  logic              underrun_q;

  logic [RGB_W-1:0]  fifo_dout;
  logic [PW:0]       fifo_count;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic [PW+1:0]     occupancy;
  logic              disp_rd, cpu_grant, cpu_is_wr;

  // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy = {1'b0, fifo_count} + (PW+2)'(rd_vld_q);
  assign disp_rd   = !frame_start && (state_q == ST_FETCH) && (occupancy < DEPTH_L);
  assign cpu_grant = !frame_start && !disp_rd && cpu_valid;

`ifdef VGA_FB_CPU_RD_EN
  assign cpu_is_wr = cpu_we;
`else
  assign cpu_is_wr = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      rd_vld_q     <= rd_vld_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    rd_vld_d     = disp_rd;
    if (frame_start) begin
      state_d      = ST_FETCH;
      fetch_addr_d = '0;
    end else if (disp_rd) begin
      fetch_addr_d = fetch_addr_q + 1'b1;
      if (fetch_addr_q == LAST_ADDR) state_d = ST_DONE;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    if (disp_rd) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr_q;
    end else if (cpu_grant) begin
      cpu_ready = 1'b1;
      mem_en    = 1'b1;
      mem_we    = cpu_is_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // frame_start discards a read still in flight from the previous frame.
  assign fifo_push = rd_vld_q && !frame_start;
  assign fifo_pop  = pix_en && disp_active;

  vga_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RGB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_rdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else if (pix_en) begin
      if (disp_active) begin
        rgb_q <= fifo_empty ? '0 : fifo_dout;
        if (fifo_empty) underrun_q <= 1'b1;
      end else begin
        rgb_q <= '0;
      end
    end
  end

  assign rgb      = rgb_q;
  assign underrun = underrun_q;

`ifdef VGA_FB_CPU_RD_EN
  logic             cpu_rvalid_q;
  logic [RGB_W-1:0] cpu_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_grant && !cpu_we;
      if (cpu_rvalid_q) cpu_rdata_q <= mem_rdata;
    end
  end

  // RAM data is presented on the rvalid cycle and held in cpu_rdata_q afterwards.
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
`endif

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Bench for vga_fb_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_vga_fb_ctrl;
  localparam int H = 16, V = 4, N = H * V, AW = 19, DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic frame_start = 1'b0, pix_en = 1'b0, disp_active = 1'b0, cpu_valid = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [11:0]   cpu_wdata = '0;
  logic          cpu_ready, underrun, mem_en, mem_we;
  logic [11:0]   rgb, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef VGA_FB_CPU_RD_EN
  logic          cpu_we = 1'b1;
  logic [11:0]   cpu_rdata;
  logic          cpu_rvalid;
`endif

  always #5 clk = ~clk;

  vga_fb_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_en(pix_en),
    .disp_active(disp_active), .rgb(rgb), .underrun(underrun),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef VGA_FB_CPU_RD_EN
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Frame-buffer RAM; reset reloads RAM[i]=i.
  logic [11:0] ram [512];
  logic [11:0] rdata_q = '0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) ram[i] <= 12'(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
      else        rdata_q <= ram[mem_addr[8:0]];
    end
  end
  assign mem_rdata = rdata_q;

  int vectors = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of pixel values in raster order plus a fetch pointer.
  logic [11:0] q[$];
  bit          m_fetch, m_infl, m_under, last_grant, m_crv;
  int          m_addr, last_disp;
  logic [11:0] m_inval, m_rgb, m_crd;

  always @(negedge clk) begin
    bit disp, grant, exp_we;
    if (rst) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_underrun", underrun, 0);
`ifdef VGA_FB_CPU_RD_EN
      chk("rst_rvalid", cpu_rvalid, 0);
      chk("rst_rdata", cpu_rdata, 0);
`endif
      q.delete();
      m_fetch = 0; m_infl = 0; m_under = 0; m_addr = 0; m_rgb = '0;
      last_grant = 0; m_crv = 0; last_disp = -1;
    end else begin
      disp  = !frame_start && m_fetch && (q.size() + int'(m_infl) < DEPTH);
      grant = !frame_start && !disp && cpu_valid;
`ifdef VGA_FB_CPU_RD_EN
      exp_we = cpu_we;
`else
      exp_we = 1'b1;
`endif
      chk("mem_en", mem_en, disp || grant);
      chk("cpu_ready", cpu_ready, grant);
      if (disp) begin
        chk("disp_we", mem_we, 0);
        chk("disp_addr", mem_addr, m_addr);
        last_disp = int'(mem_addr);
      end
      if (grant) begin
        chk("cpu_we", mem_we, exp_we);
        chk("cpu_addr", mem_addr, cpu_addr);
        if (exp_we) chk("cpu_wdata", mem_wdata, cpu_wdata);
      end
      chk("rgb", rgb, m_rgb);
      chk("underrun", underrun, m_under);
`ifdef VGA_FB_CPU_RD_EN
      chk("cpu_rvalid", cpu_rvalid, m_crv);
      if (m_crv) chk("cpu_rdata", cpu_rdata, m_crd);
`endif
      if (pix_en) begin
        if (disp_active) begin
          if (q.size() > 0) m_rgb = q.pop_front();
          else begin m_rgb = '0; m_under = 1; end
        end else m_rgb = '0;
      end
      if (frame_start) begin
        q.delete(); m_infl = 0; m_addr = 0; m_fetch = 1;
      end else begin
        if (m_infl) q.push_back(m_inval);
        m_infl = disp;
        if (disp) begin
          m_inval = ram[m_addr[8:0]];
          m_addr++;
          if (m_addr == N) m_fetch = 0;
        end
      end
      m_crv = grant && !exp_we;
      if (m_crv) m_crd = ram[cpu_addr[8:0]];
      last_grant = grant;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rnd_cycle(input bit allow_fs);
    pix_en      = 1'($urandom_range(0, 1));
    disp_active = ($urandom_range(0, 3) != 0);
    frame_start = allow_fs && ($urandom_range(0, 149) == 0);
    if (!cpu_valid || last_grant) begin
      cpu_valid = ($urandom_range(0, 2) == 0);
      cpu_addr  = AW'($urandom_range(0, 511));
      cpu_wdata = 12'($urandom);
`ifdef VGA_FB_CPU_RD_EN
      cpu_we    = 1'($urandom_range(0, 1));
`endif
    end
    step(1);
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    // Pop before any frame: black pixel, sticky underrun until reset.
    pix_en = 1; disp_active = 1;
    step(1);
    pix_en = 0; disp_active = 0;
    @(negedge clk);
    chk("t4_rgb", rgb, 12'h000);
    chk("t4_under", underrun, 1);
    step(3);
    chk("t4_sticky", underrun, 1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_cleared", underrun, 0);

    // Frame start: eight back-to-back reads, then FIFO full.
    step(1);
    frame_start = 1;
    step(1);
    frame_start = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_addr", mem_addr, k);
      chk("t1_en", mem_en, 1);
    end
    @(negedge clk);
    chk("t1_full_idle", mem_en, 0);
    @(posedge clk); #1;
    pix_en = 1; disp_active = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin pix_en = 0; disp_active = 0; end
      @(negedge clk);
      chk("t1_rgb", rgb, k);
    end

    // CPU write with the FIFO full is granted immediately.
    step(6);
    cpu_valid = 1; cpu_addr = AW'(19'h100); cpu_wdata = 12'hABC;
    @(negedge clk);
    chk("t2_ready", cpu_ready, 1);
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 19'h100);
    step(1);
    cpu_valid = 0;

    // Display read due: CPU waits one cycle.
    pix_en = 1; disp_active = 1;
    step(1);
    pix_en = 0; disp_active = 0;
    cpu_valid = 1; cpu_addr = AW'(19'h101); cpu_wdata = 12'h123;
    @(negedge clk);
    chk("t3_ready_low", cpu_ready, 0);
    chk("t3_disp_rd", {31'd0, mem_en && !mem_we}, 1);
    step(1);
    @(negedge clk);
    chk("t3_granted", cpu_ready, 1);
    step(1);
    cpu_valid = 0;

    // frame_start with a read in flight drops the return and restarts at 0.
    step(4);
    pix_en = 1; disp_active = 1;
    step(1);
    pix_en = 0; disp_active = 0;
    @(negedge clk);
    chk("t5_rd_issued", {31'd0, mem_en && !mem_we}, 1);
    step(1);
    frame_start = 1;
    step(1);
    frame_start = 0;
    pix_en = 1; disp_active = 1;
    @(negedge clk);
    chk("t5_addr0", mem_addr, 0);
    chk("t5_en", mem_en, 1);
    step(1);
    pix_en = 0; disp_active = 0;
    @(negedge clk);
    chk("t5_flushed_rgb", rgb, 12'h000);
    chk("t5_flushed_under", underrun, 1);

    // Run the rest of the frame under random traffic.
    for (int c = 0; c < 3000 && m_fetch; c++) rnd_cycle(1'b0);
    cpu_valid = 0; pix_en = 0;
    chk("t5_last_addr", last_disp, N - 1);
    step(4);
    @(negedge clk);
    chk("t5_done_idle", mem_en, 0);

    // Random traffic including frame restarts.
    for (int c = 0; c < 4000; c++) rnd_cycle(1'b1);
    frame_start = 0; pix_en = 0; disp_active = 0; cpu_valid = 0;
    step(12);

`ifdef VGA_FB_CPU_RD_EN
    begin
      bit got;
      cpu_valid = 1; cpu_we = 1; cpu_addr = AW'(5); cpu_wdata = 12'h5A5;
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin step(1); got = last_grant; end
      chk("t6_wr_granted", got, 1);
      cpu_we = 0;
      @(negedge clk);
      chk("t6_rd_granted", cpu_ready, 1);
      step(1);
      cpu_valid = 0;
      @(negedge clk);
      chk("t6_rvalid", cpu_rvalid, 1);
      chk("t6_rdata", cpu_rdata, 12'h5A5);
      chk("t6_no_disp", mem_en, 0);
      step(2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
